// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline compositor: overlay modes, RGB565 field
// positions, the blanking pixel and the per-channel blend helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        MODE_CHROMA  = 2'b00,
        MODE_OVERLAY = 2'b01,
        MODE_BLEND   = 2'b10,
        MODE_BG      = 2'b11
    } mode_e;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [15:0] BLANK_PIXEL = 16'h0000;

    // Average each RGB565 channel on its own so no carry leaks between fields.
    function automatic logic [15:0] blend565(input logic [15:0] a, input logic [15:0] b);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] bl;
        r  = 5'((6'(a[R_MSB:R_LSB]) + 6'(b[R_MSB:R_LSB])) >> 1);
        g  = 6'((7'(a[G_MSB:G_LSB]) + 7'(b[G_MSB:G_LSB])) >> 1);
        bl = 5'((6'(a[B_MSB:B_LSB]) + 6'(b[B_MSB:B_LSB])) >> 1);
        return {r, g, bl};
    endfunction

endpackage

// File: rtl/pipeline_delay_line.sv
// Fixed-depth shift register that carries the input sample alongside the
// foreground fetch so both arrive at the compositing stage together.
module pipeline_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pipeline_compositor.sv
// Composites a scaled/offset foreground over a streamed background pixel.
// Define PIPELINE_COMPOSITOR_BLEND_EN to build the 50/50 blend for mode 10.
module pipeline_compositor
    import pipeline_pkg::*;
#(
    parameter int FETCH_DELAY = 4,
    parameter int COORD_W     = 10,
    parameter int FG_W        = 320,
    parameter int FG_H        = 240
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               in_valid,
    input  logic [15:0]        bg_pixel_in,
    input  logic               output_enable,
    output logic [COORD_W-1:0] fg_pixel_request_x,
    output logic [COORD_W-1:0] fg_pixel_request_y,
    output logic               fg_pixel_request_active,
    input  logic [15:0]        fg_pixel_in,
    input  logic               fg_pixel_valid,
    output logic [15:0]        pixel_out,
    output logic [COORD_W-1:0] pixel_x_out,
    output logic [COORD_W-1:0] pixel_y_out,
    output logic               out_valid,
    input  logic [1:0]         ctrl_overlay_mode,
    input  logic [1:0]         ctrl_fg_scale,
    input  logic [COORD_W-1:0] ctrl_fg_offset_x,
    input  logic [COORD_W-1:0] ctrl_fg_offset_y,
    input  logic [15:0]        ctrl_key_colour,
    input  logic [15:0]        ctrl_key_mask,
    output logic [15:0]        fg_miss_count
);

    localparam int LINE_W = 3 + 2 * COORD_W + 16;

    mode_e              mode_q, mode_d;
    logic [1:0]         scale_q, scale_d;
    logic [COORD_W-1:0] off_x_q, off_x_d, off_y_q, off_y_d;
    logic [15:0]        key_q, key_d, mask_q, mask_d;
    logic               frame_start;

    logic [COORD_W-1:0] dx, dy;
    logic [31:0]        lim_x, lim_y;
    logic               in_window;
    logic               req_active_q, req_active_d;
    logic [COORD_W-1:0] req_x_q, req_x_d, req_y_q, req_y_d;

    logic [LINE_W-1:0]  line_in, line_out;
    logic               al_valid, al_oe, al_active;
    logic [COORD_W-1:0] al_x, al_y;
    logic [15:0]        al_bg;

    logic               fg_usable, fg_miss;
    logic [15:0]        mixed;
    logic [15:0]        pix_q, pix_d, miss_cnt_q, miss_cnt_d;
    logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic               out_valid_q, out_valid_d;

    // The _d shadow values already carry the new frame's settings on the
    // (0,0) cycle, so the first pixel of a frame is windowed with them.
    always_comb begin
        frame_start = in_valid && (pixel_x == '0) && (pixel_y == '0);
        mode_d      = frame_start ? mode_e'(ctrl_overlay_mode) : mode_q;
        scale_d     = frame_start ? ctrl_fg_scale    : scale_q;
        off_x_d     = frame_start ? ctrl_fg_offset_x : off_x_q;
        off_y_d     = frame_start ? ctrl_fg_offset_y : off_y_q;
        key_d       = frame_start ? ctrl_key_colour  : key_q;
        mask_d      = frame_start ? ctrl_key_mask    : mask_q;
    end

    always_comb begin
        dx           = pixel_x - off_x_d;
        dy           = pixel_y - off_y_d;
        lim_x        = 32'(FG_W) << scale_d;
        lim_y        = 32'(FG_H) << scale_d;
        in_window    = in_valid && (pixel_x >= off_x_d) && (pixel_y >= off_y_d) &&
                       (32'(dx) < lim_x) && (32'(dy) < lim_y);
        req_active_d = in_window;
        req_x_d      = in_window ? (dx >> scale_d) : '0;
        req_y_d      = in_window ? (dy >> scale_d) : '0;
    end

    assign line_in = {in_valid, output_enable, in_window, pixel_x, pixel_y, bg_pixel_in};

    pipeline_delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (FETCH_DELAY)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (line_in),
        .q     (line_out)
    );

    assign {al_valid, al_oe, al_active, al_x, al_y, al_bg} = line_out;

    always_comb begin
        fg_usable = al_active && fg_pixel_valid;
        fg_miss   = al_active && !fg_pixel_valid;
        mixed     = al_bg;
        case (mode_q)
            MODE_CHROMA: begin
                if (fg_usable && (((fg_pixel_in ^ key_q) & mask_q) != '0)) begin
                    mixed = fg_pixel_in;
                end
            end
            MODE_OVERLAY: begin
                if (fg_usable) begin
                    mixed = fg_pixel_in;
                end
            end
            MODE_BLEND: begin
`ifdef PIPELINE_COMPOSITOR_BLEND_EN
                if (fg_usable) begin
                    mixed = blend565(al_bg, fg_pixel_in);
                end
`else
                mixed = al_bg;
`endif
            end
            default: mixed = al_bg;
        endcase
    end

    // Pixel holds across invalid slots; coordinates just follow the pipe.
    always_comb begin
        pix_d       = al_valid ? (al_oe ? mixed : BLANK_PIXEL) : pix_q;
        out_valid_d = al_valid;
        x_out_d     = al_x;
        y_out_d     = al_y;
        miss_cnt_d  = miss_cnt_q;
        if (frame_start) begin
            miss_cnt_d = '0;
        end else if (fg_miss && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= MODE_CHROMA;
            scale_q      <= '0;
            off_x_q      <= '0;
            off_y_q      <= '0;
            key_q        <= '0;
            mask_q       <= '0;
            req_active_q <= 1'b0;
            req_x_q      <= '0;
            req_y_q      <= '0;
            pix_q        <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            out_valid_q  <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            mode_q       <= mode_d;
            scale_q      <= scale_d;
            off_x_q      <= off_x_d;
            off_y_q      <= off_y_d;
            key_q        <= key_d;
            mask_q       <= mask_d;
            req_active_q <= req_active_d;
            req_x_q      <= req_x_d;
            req_y_q      <= req_y_d;
            pix_q        <= pix_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            out_valid_q  <= out_valid_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign fg_pixel_request_active = req_active_q;
    assign fg_pixel_request_x      = req_x_q;
    assign fg_pixel_request_y      = req_y_q;
    assign pixel_out               = pix_q;
    assign pixel_x_out             = x_out_q;
    assign pixel_y_out             = y_out_q;
    assign out_valid               = out_valid_q;
    assign fg_miss_count           = miss_cnt_q;

endmodule

// File: tb/tb_pipeline_compositor.sv
// Bench for pipeline_compositor: directed scenarios plus randomized traffic
// checked against a per-pixel reference model.
module tb_pipeline_compositor;

    localparam int D   = 4;
    localparam int CW  = 10;
    localparam int FGW = 320;
    localparam int FGH = 240;
    localparam int N   = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          in_valid;
    logic [15:0]   bg_pixel_in;
    logic          output_enable;
    logic [CW-1:0] fg_pixel_request_x, fg_pixel_request_y;
    logic          fg_pixel_request_active;
    logic [15:0]   fg_pixel_in;
    logic          fg_pixel_valid;
    logic [15:0]   pixel_out;
    logic [CW-1:0] pixel_x_out, pixel_y_out;
    logic          out_valid;
    logic [1:0]    ctrl_overlay_mode, ctrl_fg_scale;
    logic [CW-1:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
    logic [15:0]   ctrl_key_colour, ctrl_key_mask;
    logic [15:0]   fg_miss_count;

    // clock / reset
    always #5 clk = ~clk;

    pipeline_compositor #(
        .FETCH_DELAY (D),
        .COORD_W     (CW),
        .FG_W        (FGW),
        .FG_H        (FGH)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pixel_x                 (pixel_x),
        .pixel_y                 (pixel_y),
        .in_valid                (in_valid),
        .bg_pixel_in             (bg_pixel_in),
        .output_enable           (output_enable),
        .fg_pixel_request_x      (fg_pixel_request_x),
        .fg_pixel_request_y      (fg_pixel_request_y),
        .fg_pixel_request_active (fg_pixel_request_active),
        .fg_pixel_in             (fg_pixel_in),
        .fg_pixel_valid          (fg_pixel_valid),
        .pixel_out               (pixel_out),
        .pixel_x_out             (pixel_x_out),
        .pixel_y_out             (pixel_y_out),
        .out_valid               (out_valid),
        .ctrl_overlay_mode       (ctrl_overlay_mode),
        .ctrl_fg_scale           (ctrl_fg_scale),
        .ctrl_fg_offset_x        (ctrl_fg_offset_x),
        .ctrl_fg_offset_y        (ctrl_fg_offset_y),
        .ctrl_key_colour         (ctrl_key_colour),
        .ctrl_key_mask           (ctrl_key_mask),
        .fg_miss_count           (fg_miss_count)
    );

    int total = 0;
    int bad   = 0;
    int cur   = -1;

    // control values applied with the next slot
    logic          n_rst;
    logic [1:0]    n_mode, n_scale;
    logic [CW-1:0] n_offx, n_offy;
    logic [15:0]   n_key, n_mask;

    // reference model state
    logic [1:0]    m_mode, m_scale;
    logic [CW-1:0] m_offx, m_offy;
    logic [15:0]   m_key, m_mask, m_pix, m_cnt;

    bit            r_v[N], r_oe[N], r_fs[N], r_act[N], r_fgv[N];
    logic [CW-1:0] r_x[N], r_y[N], r_rx[N], r_ry[N];
    logic [15:0]   r_bg[N], r_fg[N];
    logic [1:0]    h_mode[N];
    logic [15:0]   h_key[N], h_mask[N];
    bit            e_ov[N];
    logic [CW-1:0] e_x[N], e_y[N];
    logic [15:0]   e_pix[N], e_cnt[N];

    function automatic logic [15:0] mix_px(input logic [1:0] md, input logic [15:0] key,
                                           input logic [15:0] mask, input logic [15:0] bg,
                                           input logic [15:0] fg, input bit u);
        int r, g, b;
        if (md == 2'd0) return (u && (((fg ^ key) & mask) != 16'h0)) ? fg : bg;
        if (md == 2'd1) return u ? fg : bg;
`ifdef PIPELINE_COMPOSITOR_BLEND_EN
        if (md == 2'd2 && u) begin
            r = (int'(bg[15:11]) + int'(fg[15:11])) / 2;
            g = (int'(bg[10:5])  + int'(fg[10:5]))  / 2;
            b = (int'(bg[4:0])   + int'(fg[4:0]))   / 2;
            return 16'((r << 11) + (g << 5) + b);
        end
`endif
        r = 0; g = 0; b = 0;
        return bg;
    endfunction

    // One slot: predict what the DUT shows after this edge, then apply the
    // slot's inputs and the foreground answer for the pixel sent D slots ago.
    task automatic step(input bit v, input logic [CW-1:0] x, input logic [CW-1:0] y,
                        input logic [15:0] bg, input bit oe, input logic [15:0] fg, input bit fgv);
        int s, j, dx, dy;
        @(posedge clk);
        #1;
        cur++;
        s = cur;
        if (s >= N - 1) begin
            $display("FAIL slot_budget: got %0d want < %0d", s, N - 1);
            $fatal(1);
        end
        j = s - 1 - D;
        if (s >= 1 && r_fs[s-1]) m_cnt = 16'h0;
        else if (j >= 0 && r_act[j] && !r_fgv[j] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        e_ov[s] = (j >= 0) ? r_v[j] : 1'b0;
        if (e_ov[s]) begin
            e_x[s] = r_x[j];
            e_y[s] = r_y[j];
            m_pix  = r_oe[j] ? mix_px(h_mode[s-2], h_key[s-2], h_mask[s-2], r_bg[j], r_fg[j],
                                      r_act[j] && r_fgv[j]) : 16'h0000;
        end
        e_pix[s] = m_pix;
        e_cnt[s] = m_cnt;

        rst_n = n_rst;
        in_valid = v; pixel_x = x; pixel_y = y; bg_pixel_in = bg; output_enable = oe;
        ctrl_overlay_mode = n_mode; ctrl_fg_scale = n_scale;
        ctrl_fg_offset_x = n_offx; ctrl_fg_offset_y = n_offy;
        ctrl_key_colour = n_key; ctrl_key_mask = n_mask;
        fg_pixel_in    = (s >= D) ? r_fg[s-D]  : 16'h0;
        fg_pixel_valid = (s >= D) ? r_fgv[s-D] : 1'b0;

        r_v[s] = v; r_x[s] = x; r_y[s] = y; r_bg[s] = bg; r_oe[s] = oe; r_fg[s] = fg; r_fgv[s] = fgv;
        r_fs[s] = v && x == '0 && y == '0;
        if (r_fs[s]) begin
            m_mode = n_mode; m_scale = n_scale; m_offx = n_offx; m_offy = n_offy;
            m_key = n_key; m_mask = n_mask;
        end
        dx = int'(x) - int'(m_offx);
        dy = int'(y) - int'(m_offy);
        r_act[s] = v && dx >= 0 && dy >= 0 && dx < (FGW << m_scale) && dy < (FGH << m_scale);
        r_rx[s] = CW'(dx >>> m_scale);
        r_ry[s] = CW'(dy >>> m_scale);
        h_mode[s] = m_mode; h_key[s] = m_key; h_mask[s] = m_mask;
        @(negedge clk);
    endtask

    task automatic flush(input int n);
        repeat (n) step(1'b0, '0, '0, 16'h0, 1'b1, 16'h0, 1'b0);
    endtask

    task automatic configure(input logic [1:0] md, input logic [1:0] sc, input logic [CW-1:0] ox,
                             input logic [CW-1:0] oy, input logic [15:0] key, input logic [15:0] mask);
        n_mode = md; n_scale = sc; n_offx = ox; n_offy = oy; n_key = key; n_mask = mask;
        step(1'b1, '0, '0, 16'h0, 1'b1, 16'h0, 1'b1);
        flush(D + 2);
    endtask

    task automatic test_reset();
        logic [73:0] all_out;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        all_out = {pixel_out, pixel_x_out, pixel_y_out, out_valid, fg_pixel_request_x,
                   fg_pixel_request_y, fg_pixel_request_active, fg_miss_count};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        flush(2);
    endtask

    task automatic test_request();
        configure(2'd1, 2'd1, CW'(100), CW'(50), 16'h0, 16'h0);
        step(1'b1, CW'(101), CW'(50), 16'h1111, 1'b1, 16'h2222, 1'b1);
        step(1'b1, CW'(99), CW'(50), 16'h1111, 1'b1, 16'h2222, 1'b1);
        total++;
        if ({fg_pixel_request_active, fg_pixel_request_x, fg_pixel_request_y} !== {1'b1, CW'(0), CW'(0)}) begin
            bad++;
            $display("FAIL request_inside: got act=%b x=%0d y=%0d want act=1 x=0 y=0",
                     fg_pixel_request_active, fg_pixel_request_x, fg_pixel_request_y);
        end
        flush(1);
        total++;
        if (fg_pixel_request_active !== 1'b0) begin
            bad++;
            $display("FAIL request_left_of_window: got act=%b want 0", fg_pixel_request_active);
        end
        flush(D + 2);
    endtask

    task automatic test_chroma();
        configure(2'd0, 2'd0, '0, '0, 16'hF81F, 16'hFFFF);
        step(1'b1, CW'(10), CW'(10), 16'h1234, 1'b1, 16'hF81F, 1'b1);
        step(1'b1, CW'(11), CW'(10), 16'h1234, 1'b1, 16'h07E0, 1'b1);
        flush(D - 1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL chroma_latency_early: got out_valid=%b want 0", out_valid);
        end
        flush(1);
        total++;
        if ({out_valid, pixel_out} !== {1'b1, 16'h1234}) begin
            bad++;
            $display("FAIL chroma_key_hit: got v=%b pix=%h want v=1 pix=1234", out_valid, pixel_out);
        end
        flush(1);
        total++;
        if ({out_valid, pixel_out} !== {1'b1, 16'h07E0}) begin
            bad++;
            $display("FAIL chroma_key_miss: got v=%b pix=%h want v=1 pix=07e0", out_valid, pixel_out);
        end
    endtask

    task automatic test_blend();
        logic [15:0] exp;
`ifdef PIPELINE_COMPOSITOR_BLEND_EN
        exp = 16'h7BEF;
`else
        exp = 16'hFFFF;
`endif
        configure(2'd2, 2'd0, '0, '0, 16'h0, 16'h0);
        step(1'b1, CW'(5), CW'(5), 16'hFFFF, 1'b1, 16'h0000, 1'b1);
        flush(D + 1);
        total++;
        if (pixel_out !== exp) begin
            bad++;
            $display("FAIL blend_mode: got %h want %h", pixel_out, exp);
        end
    endtask

    task automatic test_blank();
        configure(2'd1, 2'd0, '0, '0, 16'h0, 16'h0);
        step(1'b1, CW'(3), CW'(3), 16'h5555, 1'b0, 16'hABCD, 1'b1);
        flush(D + 1);
        total++;
        if ({out_valid, pixel_out} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL blanking: got v=%b pix=%h want v=1 pix=0000", out_valid, pixel_out);
        end
    endtask

    task automatic test_miss();
        configure(2'd1, 2'd0, '0, '0, 16'h0, 16'h0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, CW'(i), CW'(1), 16'h0F0F, 1'b1, 16'hFFFF, 1'b0);
        end
        flush(D + 1);
        total++;
        if (fg_miss_count !== 16'd10) begin
            bad++;
            $display("FAIL miss_count: got %0d want 10", fg_miss_count);
        end
        step(1'b1, '0, '0, 16'h0, 1'b1, 16'h0, 1'b1);
        flush(1);
        total++;
        if (fg_miss_count !== 16'd0) begin
            bad++;
            $display("FAIL miss_clear: got %0d want 0", fg_miss_count);
        end
        flush(D + 2);
    endtask

    task automatic test_random();
        bit v, fs, oe, fgv;
        logic [CW-1:0] x, y;
        logic [15:0] fg;
        for (int i = 0; i < 900; i++) begin
            v   = $urandom_range(0, 9) < 8;
            fs  = $urandom_range(0, 24) == 0;
            x   = fs ? '0 : CW'($urandom_range(0, 1023));
            y   = fs ? '0 : CW'($urandom_range(0, 700));
            oe  = $urandom_range(0, 9) != 0;
            fgv = $urandom_range(0, 3) != 0;
            fg  = ($urandom_range(0, 2) == 0) ? (m_key ^ (16'($urandom) & ~m_mask)) : 16'($urandom);
            n_mode  = 2'($urandom_range(0, 3));
            n_scale = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            n_offx  = CW'($urandom_range(0, 400));
            n_offy  = CW'($urandom_range(0, 300));
            n_key   = 16'($urandom);
            n_mask  = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            step(v, x, y, 16'($urandom), oe, fg, fgv);

            total++;
            if (out_valid !== e_ov[cur]) begin
                bad++;
                $display("FAIL rand_out_valid slot %0d: got %b want %b", cur, out_valid, e_ov[cur]);
            end
            total++;
            if (pixel_out !== e_pix[cur]) begin
                bad++;
                $display("FAIL rand_pixel slot %0d: got %h want %h", cur, pixel_out, e_pix[cur]);
            end
            if (e_ov[cur]) begin
                total++;
                if ({pixel_x_out, pixel_y_out} !== {e_x[cur], e_y[cur]}) begin
                    bad++;
                    $display("FAIL rand_out_coord slot %0d: got (%0d,%0d) want (%0d,%0d)",
                             cur, pixel_x_out, pixel_y_out, e_x[cur], e_y[cur]);
                end
            end
            total++;
            if (fg_miss_count !== e_cnt[cur]) begin
                bad++;
                $display("FAIL rand_miss_count slot %0d: got %0d want %0d", cur, fg_miss_count, e_cnt[cur]);
            end
            total++;
            if (fg_pixel_request_active !== r_act[cur-1]) begin
                bad++;
                $display("FAIL rand_req_active slot %0d: got %b want %b", cur, fg_pixel_request_active, r_act[cur-1]);
            end
            if (r_act[cur-1]) begin
                total++;
                if ({fg_pixel_request_x, fg_pixel_request_y} !== {r_rx[cur-1], r_ry[cur-1]}) begin
                    bad++;
                    $display("FAIL rand_req_coord slot %0d: got (%0d,%0d) want (%0d,%0d)", cur,
                             fg_pixel_request_x, fg_pixel_request_y, r_rx[cur-1], r_ry[cur-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [73:0] all_out;
        configure(2'd1, 2'd0, '0, '0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, CW'(i + 1), CW'(3), 16'h0A0A, 1'b1, 16'hBEEF, 1'b1);
        end
        n_rst = 1'b0;
        step(1'b1, CW'(7), CW'(3), 16'h0A0A, 1'b1, 16'hBEEF, 1'b1);
        n_rst = 1'b1;
        step(1'b1, CW'(5), CW'(7), 16'h4321, 1'b1, 16'hBEEF, 1'b1);
        all_out = {pixel_out, pixel_x_out, pixel_y_out, out_valid, fg_pixel_request_x,
                   fg_pixel_request_y, fg_pixel_request_active, fg_miss_count};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h want 0", all_out);
        end
        for (int i = 1; i <= D; i++) begin
            step(1'b1, CW'(5 + i), CW'(7), 16'h1111, 1'b1, 16'hBEEF, 1'b1);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet cycle %0d: got out_valid=%b want 0", i, out_valid);
            end
        end
        flush(1);
        total++;
        if ({out_valid, pixel_out} !== {1'b1, 16'h4321}) begin
            bad++;
            $display("FAIL reset_mid_first_pixel: got v=%b pix=%h want v=1 pix=4321", out_valid, pixel_out);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; pixel_x = '0; pixel_y = '0;
        bg_pixel_in = 16'h0; output_enable = 1'b1; fg_pixel_in = 16'h0; fg_pixel_valid = 1'b0;
        ctrl_overlay_mode = 2'd0; ctrl_fg_scale = 2'd0; ctrl_fg_offset_x = '0; ctrl_fg_offset_y = '0;
        ctrl_key_colour = 16'h0; ctrl_key_mask = 16'h0;
        n_rst = 1'b1; n_mode = 2'd0; n_scale = 2'd0; n_offx = '0; n_offy = '0; n_key = 16'h0; n_mask = 16'h0;
        m_mode = 2'd0; m_scale = 2'd0; m_offx = '0; m_offy = '0; m_key = 16'h0; m_mask = 16'h0;
        m_pix = 16'h0; m_cnt = 16'h0;

        test_reset();
        test_request();
        test_chroma();
        test_blend();
        test_blank();
        test_miss();
        test_random();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
